// File: rtl/bridge_cmd_responder.sv
// bridge_cmd_responder: accepts one host command at a time, answers status/unknown commands
// internally and dispatches the rest to per-command core handlers with a timeout guard.
module bridge_cmd_responder #(
    parameter int PARAM_WORDS    = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      host_valid,
    input  logic [31:0]               host_word,
    input  logic [PARAM_WORDS*32-1:0] host_param,
    output logic                      host_done,
    output logic [31:0]               host_result,
    input  logic [7:0]                core_status,
    output logic [5:0]                hdl_valid,
    output logic [PARAM_WORDS*32-1:0] hdl_param,
    input  logic [5:0]                hdl_done,
    input  logic [6*32-1:0]           hdl_result
);
    typedef enum logic [1:0] {IDLE, DISPATCH, RESPOND, WAIT_DROP} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [5:0]                hdl_valid_q, hdl_valid_d;
    logic [PARAM_WORDS*32-1:0] hdl_param_q, hdl_param_d;
    logic [2:0]                idx_q, idx_d;
    logic [31:0]               cnt_q, cnt_d;
    logic                      host_done_q, host_done_d;
    logic [31:0]               host_result_q, host_result_d;
    logic [15:0]               id;
    logic                      tag_ok;
    logic [2:0]                dec_idx;
    logic                      dec_hit;
    logic                      expire;

    assign id      = host_word[15:0];
    assign tag_ok  = host_word[31:16] == 16'h434D;
    // index 7 marks an id with no handler
    assign dec_idx = id == 16'h0010 ? 3'd0 :
                     id == 16'h0011 ? 3'd1 :
                     id == 16'h0080 ? 3'd2 :
                     id == 16'h0082 ? 3'd3 :
                     id == 16'h008A ? 3'd4 :
                     id == 16'h008F ? 3'd5 : 3'd7;
    assign dec_hit = dec_idx != 3'd7;
    assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        hdl_valid_d   = hdl_valid_q;
        hdl_param_d   = hdl_param_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        host_done_d   = 1'b0;
        host_result_d = 32'h0;
        case (state_q)
            IDLE: if (host_valid) begin
                hdl_param_d = host_param;
                idx_d       = dec_idx;
                cnt_d       = 32'h0;
                if (tag_ok && dec_hit) begin
                    hdl_valid_d = 6'b1 << dec_idx;
                    state_d     = DISPATCH;
                end else begin
                    host_done_d   = 1'b1;
                    host_result_d = (tag_ok && id == 16'h0000) ? {24'h0, core_status} : 32'd1;
                    state_d       = RESPOND;
                end
            end
            DISPATCH: begin
                cnt_d = &cnt_q ? cnt_q : cnt_q + 32'd1;
                if (hdl_done[idx_q] || expire) begin
                    hdl_valid_d   = 6'b0;
                    host_done_d   = 1'b1;
                    host_result_d = hdl_done[idx_q] ? hdl_result[{idx_q, 5'b0} +: 32] : 32'd2;
                    state_d       = RESPOND;
                end
            end
            RESPOND:   state_d = host_valid ? WAIT_DROP : IDLE;
            WAIT_DROP: state_d = host_valid ? WAIT_DROP : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hdl_valid_q   <= '0;
            hdl_param_q   <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            host_done_q   <= 1'b0;
            host_result_q <= '0;
        end else begin
            state_q       <= state_d;
            hdl_valid_q   <= hdl_valid_d;
            hdl_param_q   <= hdl_param_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            host_done_q   <= host_done_d;
            host_result_q <= host_result_d;
        end
    end

    assign host_done   = host_done_q;
    assign host_result = host_result_q;
    assign hdl_valid   = hdl_valid_q;
    assign hdl_param   = hdl_param_q;
endmodule

// File: tb/tb_bridge_cmd_responder.sv
// tb_bridge_cmd_responder: scenario tasks with a result scoreboard for bridge_cmd_responder.
module tb_bridge_cmd_responder;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         host_valid = 1'b0;
    logic [31:0]  host_word = '0;
    logic [255:0] host_param = '0;
    logic         host_done;
    logic [31:0]  host_result;
    logic [7:0]   core_status = '0;
    logic [5:0]   hdl_valid;
    logic [255:0] hdl_param;
    logic [5:0]   hdl_done = '0;
    logic [191:0] hdl_result = '0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    bridge_cmd_responder #(.PARAM_WORDS(8), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .host_valid(host_valid), .host_word(host_word),
        .host_param(host_param), .host_done(host_done), .host_result(host_result),
        .core_status(core_status), .hdl_valid(hdl_valid), .hdl_param(hdl_param),
        .hdl_done(hdl_done), .hdl_result(hdl_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_results(input int slot, input logic [31:0] val);
        for (int i = 0; i < 6; i++) hdl_result[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
        hdl_result[slot*32 +: 32] = val;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (host_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", host_done); end
        checks++; if (host_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", host_result); end
        checks++; if (hdl_valid !== 6'h0) begin failures++; $display("FAIL reset_hdl_valid got=%b exp=0", hdl_valid); end
        checks++; if (hdl_param !== 256'h0) begin failures++; $display("FAIL reset_hdl_param got=%h exp=0", hdl_param[31:0]); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_status(input logic [7:0] st);
        logic [31:0] e;
        core_status = st;
        host_word = 32'h434D0000;
        host_valid = 1'b1;
        exp_q.push_back({24'h0, st});
        tick();
        core_status = ~st;
        checks++; if (host_done !== 1'b1) begin failures++; $display("FAIL status_latency got=%b exp=1", host_done); end
        e = exp_q.pop_front();
        checks++; if (host_result !== e) begin failures++; $display("FAIL status_result got=%h exp=%h", host_result, e); end
        checks++; if (hdl_valid !== 6'h0) begin failures++; $display("FAIL status_hdl_valid got=%b exp=0", hdl_valid); end
        host_valid = 1'b0;
        tick();
        checks++; if (host_done !== 1'b0 || host_result !== 32'h0) begin failures++; $display("FAIL status_after got=%b/%h exp=0/0", host_done, host_result); end
    endtask

    task automatic test_reset_enter();
        int done_at = 0;
        logic [31:0] e;
        fill_results(0, 32'h0);
        host_word = 32'h434D0010;
        host_param = {224'h0, 32'hDEADBEEF};
        host_valid = 1'b1;
        exp_q.push_back(32'h0);
        for (int c = 1; c <= 12 && done_at == 0; c++) begin
            tick();
            hdl_done = (c == 4) ? 6'b000001 : 6'b0;
            if (c == 1) begin
                checks++; if (hdl_param[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL enter_param got=%h exp=deadbeef", hdl_param[31:0]); end
            end
            if (host_done) done_at = c;
            else begin
                checks++; if (hdl_valid !== 6'b000001) begin failures++; $display("FAIL enter_valid c=%0d got=%b exp=000001", c, hdl_valid); end
            end
        end
        hdl_done = 6'b0;
        checks++; if (done_at != 5) begin failures++; $display("FAIL enter_latency got=%0d exp=5", done_at); end
        e = exp_q.pop_front();
        checks++; if (host_result !== e) begin failures++; $display("FAIL enter_result got=%h exp=%h", host_result, e); end
        checks++; if (hdl_valid !== 6'h0) begin failures++; $display("FAIL enter_valid_drop got=%b exp=0", hdl_valid); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (host_done !== 1'b0 || hdl_valid !== 6'h0) begin failures++; $display("FAIL enter_no_reaccept got=%b/%b exp=0/0", host_done, hdl_valid); end
        end
        host_valid = 1'b0;
        tick();
    endtask

    task automatic test_unknown();
        logic [31:0] words[2];
        logic [31:0] e;
        words[0] = 32'h434D0055;
        words[1] = 32'h12340010;
        for (int i = 0; i < 2; i++) begin
            host_word = words[i];
            host_valid = 1'b1;
            exp_q.push_back(32'd1);
            tick();
            checks++; if (host_done !== 1'b1) begin failures++; $display("FAIL unknown_latency w=%h got=%b exp=1", words[i], host_done); end
            e = exp_q.pop_front();
            checks++; if (host_result !== e) begin failures++; $display("FAIL unknown_result w=%h got=%h exp=%h", words[i], host_result, e); end
            checks++; if (hdl_valid !== 6'h0) begin failures++; $display("FAIL unknown_hdl_valid got=%b exp=0", hdl_valid); end
            host_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_timeout();
        int done_at = 0;
        int c = 0;
        logic [31:0] e;
        fill_results(4, 32'h1234_5678);
        host_word = 32'h434D008A;
        host_valid = 1'b1;
        exp_q.push_back(32'd2);
        while (c < 20 && done_at == 0) begin
            c++;
            tick();
            hdl_done = (c == 3) ? 6'b100000 : 6'b0;
            if (host_done) done_at = c;
            else begin
                checks++; if (hdl_valid !== 6'b010000) begin failures++; $display("FAIL timeout_valid c=%0d got=%b exp=010000", c, hdl_valid); end
            end
        end
        checks++; if (done_at != 9) begin failures++; $display("FAIL timeout_latency got=%0d exp=9", done_at); end
        e = exp_q.pop_front();
        checks++; if (host_result !== e) begin failures++; $display("FAIL timeout_result got=%h exp=%h", host_result, e); end
        host_valid = 1'b0;
        for (int k = c + 1; k <= 14; k++) begin
            tick();
            hdl_done = (k == 12) ? 6'b010000 : 6'b0;
            checks++; if (host_done !== 1'b0 || hdl_valid !== 6'h0) begin failures++; $display("FAIL timeout_late_done c=%0d got=%b/%b exp=0/0", k, host_done, hdl_valid); end
        end
        hdl_done = 6'b0;
    endtask

    task automatic test_collision();
        int done_at = 0;
        logic [31:0] e;
        fill_results(2, 32'h5);
        host_word = 32'h434D0080;
        host_valid = 1'b1;
        exp_q.push_back(32'h5);
        for (int c = 1; c <= 20 && done_at == 0; c++) begin
            tick();
            hdl_done = (c == 8) ? 6'b000100 : 6'b0;
            if (host_done) done_at = c;
        end
        hdl_done = 6'b0;
        checks++; if (done_at != 9) begin failures++; $display("FAIL collision_latency got=%0d exp=9", done_at); end
        e = exp_q.pop_front();
        checks++; if (host_result !== e) begin failures++; $display("FAIL collision_result got=%h exp=%h", host_result, e); end
        host_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        fill_results(3, 32'h0);
        host_word = 32'h434D0082;
        host_param = {8{32'hA5A5_0001}};
        host_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (host_done !== 1'b0 || hdl_valid !== 6'b001000) begin failures++; $display("FAIL rstmid_dispatch c=%0d got=%b/%b exp=0/001000", c, host_done, hdl_valid); end
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        host_valid = 1'b0;
        checks++; if (host_done !== 1'b0 || host_result !== 32'h0 || hdl_valid !== 6'h0 || hdl_param !== 256'h0) begin
            failures++; $display("FAIL rstmid_outputs got=%b/%h/%b/%h exp=0/0/0/0", host_done, host_result, hdl_valid, hdl_param[31:0]);
        end
        tick();
        checks++; if (host_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0", host_done); end
        core_status = 8'hA5;
        host_word = 32'h434D0000;
        host_valid = 1'b1;
        exp_q.push_back(32'h0000_00A5);
        tick();
        checks++; if (host_done !== 1'b1) begin failures++; $display("FAIL rstmid_fresh_latency got=%b exp=1", host_done); end
        e = exp_q.pop_front();
        checks++; if (host_result !== e) begin failures++; $display("FAIL rstmid_fresh_result got=%h exp=%h", host_result, e); end
        host_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_status(8'h03);
        test_reset_enter();
        test_unknown();
        test_timeout();
        test_collision();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bridge_cmd_responder.md
# bridge_cmd_responder

Host-to-core command responder: the counterpart of the core-initiated request path. Accepts one host command at a time from the bridge command decoder, answers Request Status and malformed or unknown commands internally, and dispatches supported commands to per-command core handlers over a valid/done handshake. Each command returns exactly one done pulse and one result word to the decoder, with a cycle-count timeout guarding against a hung handler.

## Interface
- `PARAM_WORDS`, default 8: number of 32-bit parameter words carried per command.
- `TIMEOUT_CYCLES`, default 65535: handler timeout in clk cycles; 0 disables the timeout.
- `clk` in 1: bridge clock. One clock domain only.
- `reset_n` in 1: synchronous, active-low reset.
- `host_valid` in 1: command present. Held high by the decoder until it sees `host_done`.
- `host_word` in 32: command word. [31:16] is the tag and must be 16'h434D; [15:0] is the command id.
- `host_param` in PARAM_WORDS*32: command parameters. Valid when `host_valid` is high.
- `host_done` out 1: one-cycle pulse that completes the command.
- `host_result` out 32: result word. Valid only in the cycle `host_done` is high; 0 at all other times.
- `core_status` in 8: core state, reported by Request Status.
- `hdl_valid` out 6: one-hot handler request.
- `hdl_param` out PARAM_WORDS*32: parameters captured at command accept. Broadcast to all handlers.
- `hdl_done` in 6: handler completion, one bit per handler.
- `hdl_result` in 6*32: handler results. Handler i drives bits [32i+31:32i].
- Handler index map:
  - 0: reset_enter, id 0x0010
  - 1: reset_exit, id 0x0011
  - 2: dataslot_request_read, id 0x0080
  - 3: dataslot_request_write, id 0x0082
  - 4: dataslot_update, id 0x008A
  - 5: dataslot_all_complete, id 0x008F

## Operation
- States: IDLE, DISPATCH, RESPOND, WAIT_DROP.
- IDLE with `host_valid`=1: register `host_word` and `host_param` into `hdl_param`, then decode.
  - Tag wrong: go to RESPOND, result 1 (unknown).
  - Id 0x0000 (Request Status): go to RESPOND, result {24'h0, `core_status`}, with `core_status` sampled in the accept cycle.
  - Id in the handler map: set `hdl_valid[i]`=1, clear the timeout counter, go to DISPATCH.
  - Any other id: go to RESPOND, result 1.
- DISPATCH:
  - `hdl_valid[i]` is held high.
  - `hdl_done[i]`=1: capture `hdl_result[i]` verbatim, drop `hdl_valid`, go to RESPOND.
  - `hdl_done` bits other than i are ignored, as is any `hdl_done` bit outside DISPATCH.
  - The counter increments every DISPATCH cycle. With `TIMEOUT_CYCLES`≠0 and counter == `TIMEOUT_CYCLES`-1 and no done, drop `hdl_valid`, go to RESPOND, result 2 (timeout).
  - Done and expiry in the same cycle: done wins and the handler result is returned.
  - The counter is 32-bit and saturates; it never wraps.
- RESPOND:
  - `host_done`=1 and `host_result` = latched result, for exactly one cycle.
  - If `host_valid`=0 in this cycle, go to IDLE; otherwise go to WAIT_DROP.
- WAIT_DROP: `host_valid` is ignored as a new command. Go to IDLE on the first cycle `host_valid`=0.
- A handler that completes after a timeout gets no acknowledgement. Its late `hdl_done` is ignored.
- `hdl_param` stays stable from accept until the next accept.
- Result codes: 0 = OK (handlers' own convention), 1 = unknown, 2 = timeout. Handler codes pass through unmodified.

## Timing
- Reset (`reset_n`=0 at a clk edge), effective at any point, including mid-DISPATCH:
  - state becomes IDLE;
  - `host_done`=0, `host_result`=0, `hdl_valid`=0, `hdl_param`=0;
  - timeout counter = 0.
  - A pending command is abandoned without a done pulse; the decoder must reissue it.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Internal commands: accept in cycle 0, `host_done` in cycle 1.
- Handler commands:
  - Accept in cycle 0; `hdl_valid` is high from cycle 1.
  - `hdl_done` seen in cycle k (k≥1) gives `hdl_valid` low and `host_done` high in cycle k+1.
  - The minimum accept-to-done latency is 2 cycles.
- Timeout: with T=`TIMEOUT_CYCLES`, `hdl_valid` is high for cycles 1..T and `host_done` rises in cycle T+1.
- Throughput: the next accept happens no earlier than 1 cycle after `host_valid` is seen low following `host_done`.

## Test plan
- Request status: `host_word`=0x434D0000, `core_status`=0x03 → `host_done` in cycle 1, `host_result`=0x00000003, `hdl_valid` stays 0.
- reset_enter, normal completion:
  - Stimulus: `host_word`=0x434D0010, `host_param` word0=0xDEADBEEF; handler raises `hdl_done[0]` in cycle 4 with result 0.
  - Required: `hdl_valid`=6'b000001 in cycles 1-4, `hdl_param`[31:0]=0xDEADBEEF, `host_done` in cycle 5, `host_result`=0.
  - Afterwards: `host_valid` held 3 more cycles → no second accept.
- Unknown and bad tag: `host_word`=0x434D0055, then 0x12340010 → each gives `host_done` in cycle 1 with result 1 and no `hdl_valid`.
- Timeout: TIMEOUT_CYCLES=8, dataslot_update with no `hdl_done` → `hdl_valid[4]` high cycles 1-8, `host_done` cycle 9 with result 2; a `hdl_done[4]` in cycle 12 is ignored.
- Done/timeout collision: TIMEOUT_CYCLES=8, `hdl_done[2]` with result 0x5 in cycle 8 → `host_done` cycle 9, `host_result`=0x5.
- Reset mid-dispatch: `reset_n`=0 in cycle 3 of dataslot_request_write → next cycle all outputs 0, no `host_done`; a fresh command after reset is accepted normally.
